// File: rtl/RISCV_pkg.sv
// Shared RISC-V front-end types: next-PC select, branch condition and the
// machine word, plus the branch-condition evaluator used by pc_gen.
package RISCV_pkg;

    localparam int XLEN_DEF = 32;

    typedef logic [XLEN_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        PC_4  = 2'd0,
        PC_B  = 2'd1,
        PC_J  = 2'd2,
        PC_JR = 2'd3
    } pc_src_t;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLT  = 3'd2,
        BGE  = 3'd3,
        BLTU = 3'd4,
        BGEU = 3'd5
    } br_cond_t;

    // Undefined condition encodings resolve to not-taken.
    function automatic logic br_eval(br_cond_t c, logic zero, logic lt, logic ltu);
        logic r;
        r = 1'b0;
        case (c)
            BEQ:     r = zero;
            BNE:     r = !zero;
            BLT:     r = lt;
            BGE:     r = !lt;
            BLTU:    r = ltu;
            BGEU:    r = !ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/status bundle between the decode stage (master) and pc_gen (slave).
// Return-address-stack signals exist only when PC_RAS_EN is defined.
interface pc_gen_if #(parameter int XLEN = 32);
    import RISCV_pkg::*;

    logic            stall;
    pc_src_t         pc_src;
    br_cond_t        br_cond;
    logic            alu_zero;
    logic            alu_lt;
    logic            alu_ltu;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic            taken;
    logic            misalign;
    logic [XLEN-1:0] bad_addr;
`ifdef PC_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    modport master (
        output stall, pc_src, br_cond, alu_zero, alu_lt, alu_ltu, imm, rs1_val,
               trap_req, trap_vec, ras_push, ras_pop,
        input  pc_out, pc_plus4, taken, misalign, bad_addr, ras_top, ras_empty
    );
    modport slave (
        input  stall, pc_src, br_cond, alu_zero, alu_lt, alu_ltu, imm, rs1_val,
               trap_req, trap_vec, ras_push, ras_pop,
        output pc_out, pc_plus4, taken, misalign, bad_addr, ras_top, ras_empty
    );
`else
    modport master (
        output stall, pc_src, br_cond, alu_zero, alu_lt, alu_ltu, imm, rs1_val,
               trap_req, trap_vec,
        input  pc_out, pc_plus4, taken, misalign, bad_addr
    );
    modport slave (
        input  stall, pc_src, br_cond, alu_zero, alu_lt, alu_ltu, imm, rs1_val,
               trap_req, trap_vec,
        output pc_out, pc_plus4, taken, misalign, bad_addr
    );
`endif

endinterface

// File: rtl/pc_gen_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the
// oldest entry, a pop when empty is ignored, push+pop replaces the top.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;

    assign empty_o = (cnt_q == '0);
    assign top_o   = empty_o ? '0 : mem_q[top_q];

    // top_q indexes the newest entry; index arithmetic wraps since depth is 2^PW.
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = top_q;
        if (push_i && pop_i && !empty_o) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            wr_en  = 1'b1;
            wr_idx = top_q + PW'(1);
            top_d  = top_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH))
                cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with branch/jump/trap redirect and
// misaligned-target detection. Define PC_RAS_EN to add the return-address stack.
module pc_gen
    import RISCV_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_gen: RAS_DEPTH must be a power of two, at least 2");
    end

    logic [XLEN-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    logic            cond;
    logic            redirect;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;

    assign seq_pc = pc_q + XLEN'(4);

    always_comb begin
        cond     = br_eval(bus.br_cond, bus.alu_zero, bus.alu_lt, bus.alu_ltu);
        target   = seq_pc;
        redirect = 1'b0;
        case (bus.pc_src)
            PC_B: begin
                if (cond) begin
                    target   = pc_q + bus.imm;
                    redirect = 1'b1;
                end
            end
            PC_J: begin
                target   = pc_q + bus.imm;
                redirect = 1'b1;
            end
            PC_JR: begin
                target   = (bus.rs1_val + bus.imm) & {{(XLEN-1){1'b1}}, 1'b0};
                redirect = 1'b1;
            end
            default: begin
                target   = seq_pc;
                redirect = 1'b0;
            end
        endcase
    end

    // Trap beats stall; a misaligned target (bit1 set) leaves the PC where it is.
    always_comb begin
        pc_d       = pc_q;
        taken_d    = taken_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        if (bus.trap_req) begin
            pc_d    = bus.trap_vec;
            taken_d = 1'b1;
        end else if (!bus.stall) begin
            if (target[1]) begin
                misalign_d = 1'b1;
                bad_addr_d = target;
                taken_d    = 1'b0;
            end else begin
                pc_d    = target;
                taken_d = redirect;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            taken_q    <= taken_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.pc_plus4 = seq_pc;
    assign bus.taken    = taken_q;
    assign bus.misalign = misalign_q;
    assign bus.bad_addr = bad_addr_q;

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (!bus.stall && bus.ras_push),
        .pop_i   (!bus.stall && bus.ras_pop),
        .data_i  (seq_pc),
        .top_o   (bus.ras_top),
        .empty_o (bus.ras_empty)
    );
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic against a
// behavioural model. Exercises the return-address stack when PC_RAS_EN is defined.
module tb_pc_gen;
    import RISCV_pkg::*;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(XLEN)) bus();

    pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .RAS_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_pc, m_bad;
    logic        m_taken, m_mis;
    logic [31:0] m_ras[$];

    function automatic void model_reset();
        m_pc = RV; m_taken = 1'b0; m_mis = 1'b0; m_bad = 32'h0;
        m_ras.delete();
    endfunction

    // Next state from the architectural rules, evaluated on the inputs present before the edge.
    function automatic void model_update();
        bit          c;
        bit          redir;
        logic [31:0] tgt;
        c = 1'b0;
        if (bus.br_cond == BEQ)  c = bus.alu_zero;
        if (bus.br_cond == BNE)  c = !bus.alu_zero;
        if (bus.br_cond == BLT)  c = bus.alu_lt;
        if (bus.br_cond == BGE)  c = !bus.alu_lt;
        if (bus.br_cond == BLTU) c = bus.alu_ltu;
        if (bus.br_cond == BGEU) c = !bus.alu_ltu;
        tgt = m_pc + 32'd4;
        redir = 1'b0;
        if (bus.pc_src == PC_J || (bus.pc_src == PC_B && c)) begin
            tgt = m_pc + bus.imm; redir = 1'b1;
        end else if (bus.pc_src == PC_JR) begin
            tgt = bus.rs1_val + bus.imm;
            tgt[0] = 1'b0;
            redir = 1'b1;
        end
`ifdef PC_RAS_EN
        if (!bus.stall) begin
            if (bus.ras_push && bus.ras_pop && m_ras.size() > 0) begin
                m_ras[m_ras.size()-1] = m_pc + 32'd4;
            end else if (bus.ras_push) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end else if (bus.ras_pop && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
`endif
        m_mis = 1'b0;
        if (bus.trap_req) begin
            m_pc = bus.trap_vec; m_taken = 1'b1;
        end else if (!bus.stall) begin
            if (tgt[1]) begin
                m_mis = 1'b1; m_bad = tgt; m_taken = 1'b0;
            end else begin
                m_pc = tgt; m_taken = redir;
            end
        end
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.pc_src = PC_4; bus.br_cond = BEQ;
        bus.alu_zero = 0; bus.alu_lt = 0; bus.alu_ltu = 0;
        bus.imm = 0; bus.rs1_val = 0; bus.trap_req = 0; bus.trap_vec = 0;
`ifdef PC_RAS_EN
        bus.ras_push = 0; bus.ras_pop = 0;
`endif
    endtask

    task automatic redirect_to(input logic [31:0] a);
        bus.trap_req = 1; bus.trap_vec = a;
        tick();
        bus.trap_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        vectors++; if (bus.pc_out !== RV) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc_out, RV); end
        vectors++; if ({bus.taken, bus.misalign} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus.taken, bus.misalign}); end
        vectors++; if (bus.bad_addr !== 32'h0) begin errors++; $display("FAIL reset_bad_addr: got %h want 0", bus.bad_addr); end
`ifdef PC_RAS_EN
        vectors++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin errors++; $display("FAIL reset_ras: got empty=%b top=%h want 1/0", bus.ras_empty, bus.ras_top); end
`endif
        @(negedge clk);
        rst_n = 1;
        #1;
        vectors++; if (bus.pc_out !== 32'h100) begin errors++; $display("FAIL reset_first_fetch: got %h want 100", bus.pc_out); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++; if (bus.pc_out !== 32'h100 + 32'(4*i)) begin errors++; $display("FAIL reset_seq%0d: got %h want %h", i, bus.pc_out, 32'h100 + 32'(4*i)); end
        end
        vectors++; if (bus.pc_plus4 !== 32'h110) begin errors++; $display("FAIL pc_plus4: got %h want 110", bus.pc_plus4); end
    endtask

    task automatic test_branch();
        redirect_to(32'h20);
        bus.pc_src = PC_B; bus.br_cond = BLTU; bus.alu_ltu = 1; bus.imm = 32'hFFFF_FFF0;
        tick();
        vectors++; if (bus.pc_out !== 32'h10 || bus.taken !== 1'b1) begin errors++; $display("FAIL branch_taken: got pc=%h taken=%b want 10/1", bus.pc_out, bus.taken); end
        idle_inputs();
        redirect_to(32'h20);
        bus.pc_src = PC_B; bus.br_cond = BLTU; bus.alu_ltu = 0; bus.imm = 32'hFFFF_FFF0;
        tick();
        vectors++; if (bus.pc_out !== 32'h24 || bus.taken !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got pc=%h taken=%b want 24/0", bus.pc_out, bus.taken); end
        idle_inputs();
    endtask

    task automatic test_jalr();
        bus.pc_src = PC_JR; bus.rs1_val = 32'h1001; bus.imm = 32'h4;
        tick();
        vectors++; if (bus.pc_out !== 32'h1004 || bus.taken !== 1'b1) begin errors++; $display("FAIL jalr: got pc=%h taken=%b want 1004/1", bus.pc_out, bus.taken); end
        bus.rs1_val = 32'h1002; bus.imm = 32'h0;
        tick();
        vectors++; if (bus.pc_out !== 32'h1004 || bus.misalign !== 1'b1 || bus.taken !== 1'b0) begin errors++; $display("FAIL jalr_misalign: got pc=%h mis=%b taken=%b want 1004/1/0", bus.pc_out, bus.misalign, bus.taken); end
        vectors++; if (bus.bad_addr !== 32'h1002) begin errors++; $display("FAIL bad_addr: got %h want 1002", bus.bad_addr); end
        idle_inputs();
        tick();
        vectors++; if (bus.misalign !== 1'b0 || bus.bad_addr !== 32'h1002 || bus.pc_out !== 32'h1008) begin errors++; $display("FAIL misalign_pulse: got mis=%b bad=%h pc=%h want 0/1002/1008", bus.misalign, bus.bad_addr, bus.pc_out); end
    endtask

    task automatic test_stall_trap();
        bus.stall = 1; bus.pc_src = PC_J; bus.imm = 32'h40;
        tick();
        vectors++; if (bus.pc_out !== 32'h1008 || bus.misalign !== 1'b0) begin errors++; $display("FAIL stall_hold: got pc=%h mis=%b want 1008/0", bus.pc_out, bus.misalign); end
        bus.trap_req = 1; bus.trap_vec = 32'h800;
        tick();
        vectors++; if (bus.pc_out !== 32'h800 || bus.taken !== 1'b1) begin errors++; $display("FAIL stall_trap: got pc=%h taken=%b want 800/1", bus.pc_out, bus.taken); end
        idle_inputs();
    endtask

    task automatic test_wrap_reset();
        redirect_to(32'hFFFF_FFFC);
        tick();
        vectors++; if (bus.pc_out !== 32'h0 || bus.taken !== 1'b0) begin errors++; $display("FAIL wrap: got pc=%h taken=%b want 0/0", bus.pc_out, bus.taken); end
        bus.stall = 1; bus.pc_src = PC_J; bus.imm = 32'h40;
        tick();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        vectors++; if (bus.pc_out !== RV || bus.taken !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: got pc=%h taken=%b want %h/0", bus.pc_out, bus.taken, RV); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        #1;
        vectors++; if (bus.pc_out !== RV) begin errors++; $display("FAIL reset_release: got %h want %h", bus.pc_out, RV); end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [31:0] exp_top;
        bus.ras_push = 1;
        for (int i = 0; i < 5; i++) tick();
        bus.ras_push = 0;
        for (int i = 0; i < 4; i++) begin
            exp_top = RV + 32'(4 * (5 - i));
            vectors++; if (bus.ras_top !== exp_top || bus.ras_empty !== 1'b0) begin errors++; $display("FAIL ras_pop%0d: got top=%h empty=%b want %h/0", i, bus.ras_top, bus.ras_empty, exp_top); end
            bus.ras_pop = 1;
            tick();
            bus.ras_pop = 0;
        end
        vectors++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin errors++; $display("FAIL ras_drained: got empty=%b top=%h want 1/0", bus.ras_empty, bus.ras_top); end
        bus.ras_pop = 1;
        tick();
        bus.ras_pop = 0;
        vectors++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin errors++; $display("FAIL ras_pop_empty: got empty=%b top=%h want 1/0", bus.ras_empty, bus.ras_top); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_top;
        for (int n = 0; n < 300; n++) begin
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.trap_req = ($urandom_range(0, 15) == 0);
            bus.trap_vec = $urandom() & 32'hFFFF_FFFC;
            bus.pc_src   = pc_src_t'($urandom_range(0, 3));
            bus.br_cond  = br_cond_t'($urandom_range(0, 5));
            bus.alu_zero = 1'($urandom());
            bus.alu_lt   = 1'($urandom());
            bus.alu_ltu  = 1'($urandom());
            bus.imm      = ($urandom_range(0, 5) == 0) ? $urandom() : (($urandom() & 32'hFFFC) - 32'h8000);
            bus.rs1_val  = $urandom();
`ifdef PC_RAS_EN
            bus.ras_push = 1'($urandom());
            bus.ras_pop  = 1'($urandom());
`endif
            tick();
            vectors++; if (bus.pc_out !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h", n, bus.pc_out, bus.pc_plus4, m_pc); end
            vectors++; if (bus.taken !== m_taken || bus.misalign !== m_mis || bus.bad_addr !== m_bad) begin errors++; $display("FAIL rnd_flags[%0d]: got t=%b m=%b bad=%h want t=%b m=%b bad=%h", n, bus.taken, bus.misalign, bus.bad_addr, m_taken, m_mis, m_bad); end
`ifdef PC_RAS_EN
            exp_top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
            vectors++; if (bus.ras_top !== exp_top || bus.ras_empty !== (m_ras.size() == 0)) begin errors++; $display("FAIL rnd_ras[%0d]: got top=%h empty=%b want %h/%b", n, bus.ras_top, bus.ras_empty, exp_top, m_ras.size() == 0); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr();
        test_stall_trap();
        test_wrap_reset();
`ifdef PC_RAS_EN
        test_ras();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, program counter and datapath width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-004 SHALL have ports: clk  in  1  clock; rising edge active.
REQ-005 SHALL have ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports: stall  in  1  hold PC; fetch not ready.
REQ-007 SHALL have ports: pc_src  in  pc_src_t  next-PC select: PC_4, PC_B, PC_J, PC_JR.
REQ-008 SHALL have ports: br_cond  in  br_cond_t  BEQ, BNE, BLT, BGE, BLTU, BGEU.
REQ-009 SHALL have ports: alu_zero, alu_lt, alu_ltu  in  1 each  ALU compare flags.
REQ-010 SHALL have ports: imm  in  XLEN  sign-extended offset; rs1_val  in  XLEN  JALR base.
REQ-011 SHALL have ports: trap_req  in  1  redirect request; trap_vec  in  XLEN  redirect target.
REQ-012 SHALL have ports: pc_out  out  XLEN  current PC; pc_plus4  out  XLEN  pc_out+4, link value.
REQ-013 SHALL have ports: taken  out  1  registered: last update was a redirect other than PC_4.
REQ-014 SHALL have ports: misalign  out  1  one-cycle misaligned-target pulse; bad_addr  out  XLEN  offending target.

Function
REQ-015 SHALL compute the branch condition as BEQ=zero, BNE=!zero, BLT=lt, BGE=!lt, BLTU=ltu, BGEU=!ltu.
REQ-016 SHALL compute the target as PC_4: pc+4; PC_B: pc+imm if condition true, else pc+4; PC_J: pc+imm; PC_JR: (rs1_val+imm) with bit0 cleared.
REQ-017 SHALL wrap all additions modulo 2^XLEN with no overflow flag.
REQ-018 SHALL load the target into pc_out on the rising clock edge when stall=0, giving latency one cycle.
REQ-019 SHALL hold pc_out, taken and the RAS when stall=1, and SHALL drive misalign=0 during a stall.
REQ-020 SHALL load trap_vec when trap_req=1, overriding stall and pc_src, and SHALL drive taken=1 and misalign=0.
REQ-021 SHALL treat a target with bit1=1 as misaligned: pc_out holds, misalign=1 for one cycle, bad_addr=target, taken=0.
REQ-022 SHALL treat an illegal or undefined pc_src encoding as PC_4.
REQ-023 SHALL drive pc_plus4 combinationally from pc_out.
REQ-024 SHALL hold bad_addr until the next misalign pulse.

Reset
REQ-025 SHALL, while rst_n=0, force pc_out=RESET_VEC, taken=0, misalign=0, bad_addr=0 and RAS empty, asynchronously.
REQ-026 SHALL abandon any update in flight when reset asserts mid-operation, and SHALL fetch RESET_VEC in the first cycle after release.

Configuration
REQ-027 SHALL, with PC_RAS_EN defined, include a return-address stack: inputs ras_push and ras_pop (1 bit each), output ras_top (XLEN) and output ras_empty (1 bit).
REQ-028 SHALL, with PC_RAS_EN defined, push pc_plus4 on a non-stalled cycle with ras_push=1, and pop on a non-stalled cycle with ras_pop=1.
REQ-029 SHALL, with PC_RAS_EN defined and both push and pop asserted, replace the top entry.
REQ-030 SHALL, with PC_RAS_EN defined, overwrite the oldest entry on a push when full (circular), and SHALL ignore a pop when empty; ras_top=0 when empty.
REQ-031 SHALL, without PC_RAS_EN defined, have none of the RAS ports or storage.

Structure
REQ-032 SHALL take pc_src_t, br_cond_t and word_t from RISCV_pkg; pc_src_t SHALL gain PC_JR, and br_cond_t SHALL be added there.
REQ-033 SHALL place the RAS in a sub-module pc_ras, parameterised by XLEN and RAS_DEPTH.

Verification
REQ-034 SHALL verify reset: rst_n low, then high, with RESET_VEC=0x100, PC_4 for 3 cycles -> pc_out = 0x100, 0x104, 0x108, 0x10C.
REQ-035 SHALL verify branches: pc=0x20, PC_B, BLTU, alu_ltu=1, imm=0xFFFFFFF0 -> pc=0x10, taken=1; same stimulus with alu_ltu=0 -> pc=0x24, taken=0.
REQ-036 SHALL verify JALR: PC_JR, rs1_val=0x1001, imm=4 -> pc=0x1004; rs1_val=0x1002, imm=0 -> pc holds, misalign pulse, bad_addr=0x1002.
REQ-037 SHALL verify stall and trap: stall=1 with PC_J -> pc holds; stall=1 with trap_req=1 and trap_vec=0x800 -> pc=0x800, taken=1.
REQ-038 SHALL verify wrap: pc=0xFFFFFFFC with PC_4 -> pc=0x0; reset asserted mid-stall -> pc=RESET_VEC immediately.
REQ-039 SHALL verify the RAS under PC_RAS_EN with RAS_DEPTH=4: 5 pushes, then 4 pops -> returns in reverse order, first push lost; a fifth pop leaves ras_empty=1 and ras_top=0.
